// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types for the multi-cycle-aware hazard controller.
// Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // EXEC operand mux select
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam int c_DEF_REG_ADDR_W = 5;
    localparam int c_DEF_MC_DEPTH   = 2;
    localparam int c_DEF_CNT_W      = 32;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Pending-destination bits and in-flight count for multi-cycle ops.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int REG_ADDR_W = c_DEF_REG_ADDR_W,
    parameter  int MC_DEPTH   = c_DEF_MC_DEPTH,
    localparam int NUM_REGS   = 2**REG_ADDR_W,
    localparam int CNT_BITS   = $clog2(MC_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic                  i_issue,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic                  i_done,
    input  logic [REG_ADDR_W-1:0] i_done_rd,
    input  logic                  i_clr,
    output logic [NUM_REGS-1:0]   o_pending,
    output logic                  o_full,
    output logic                  o_busy,
    output logic                  o_err
);

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_BITS-1:0] r_count;
    logic                r_err;

    logic                w_full;
    logic                w_issue_ok;
    logic                w_done_ok;
    logic                w_new_err;
    logic [NUM_REGS-1:0] w_pending_nxt;

    assign w_full     = (r_count == CNT_BITS'(MC_DEPTH));
    assign w_issue_ok = i_issue & ~w_full;
    assign w_done_ok  = i_done & r_pending[i_done_rd];
    assign w_new_err  = (i_issue & w_full) | (i_done & ~r_pending[i_done_rd]);

    // Clear first, then set, so a same-register issue+retire leaves the bit set
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_done_ok) begin
            w_pending_nxt[i_done_rd] = 1'b0;
        end
        if (w_issue_ok) begin
            w_pending_nxt[i_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_pending <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_count   <= r_count + CNT_BITS'(w_issue_ok) - CNT_BITS'(w_done_ok);
            if (i_clr) begin
                r_err <= 1'b0;
            end else if (w_new_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_full    = w_full;
    assign o_busy    = (r_count != '0);
    assign o_err     = r_err;

endmodule
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_mc
// Description : 5-stage hazard controller: forwarding, load-use and multi-cycle
//               stalls, branch flush, saturating stall/flush counters.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = c_DEF_REG_ADDR_W,
    parameter int MC_DEPTH   = c_DEF_MC_DEPTH,
    parameter int CNT_W      = c_DEF_CNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
    input  logic                  i_rs1_used_dec,
    input  logic                  i_rs2_used_dec,
    input  logic                  i_mc_op_dec,
    input  logic                  i_mc_issue_exec,
    input  logic                  i_mc_done,
    input  logic [REG_ADDR_W-1:0] i_mc_rd,
    input  logic                  i_reg_we_mem,
    input  logic                  i_reg_we_wb,
    input  logic                  i_pc_src_exec,
    input  logic                  i_load_instr_exec,
    input  logic                  i_stall_i,
    input  logic                  i_stall_d,
    input  logic                  i_cnt_clr,
    output logic                  o_stall_fetch,
    output logic                  o_stall_dec,
    output logic                  o_stall_exec,
    output logic                  o_stall_mem,
    output logic                  o_flush_dec,
    output logic                  o_flush_exec,
    output fwd_sel_t              o_forward_rs1,
    output fwd_sel_t              o_forward_rs2,
    output logic                  o_mc_busy,
    output logic                  o_sb_err,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    localparam int NUM_REGS = 2**REG_ADDR_W;

    logic [NUM_REGS-1:0] w_pending;
    logic                w_sb_full;
    logic                w_load_use;
    logic                w_mc_stall;
    logic                w_hazard_stall;
    logic                w_issue;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    // MEM result is younger than WB, so it takes priority; x0 is never forwarded
    function automatic fwd_sel_t fwd_pick(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_mem,
        input logic                  we_mem,
        input logic [REG_ADDR_W-1:0] rd_wb,
        input logic                  we_wb
    );
        if (we_mem && (rd_mem != '0) && (rd_mem == rs)) begin
            return FWD_MEM;
        end else if (we_wb && (rd_wb != '0) && (rd_wb == rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    assign o_forward_rs1 = fwd_pick(i_rs1_addr_exec, i_rd_addr_mem, i_reg_we_mem,
                                    i_rd_addr_wb, i_reg_we_wb);
    assign o_forward_rs2 = fwd_pick(i_rs2_addr_exec, i_rd_addr_mem, i_reg_we_mem,
                                    i_rd_addr_wb, i_reg_we_wb);

    assign w_load_use = i_load_instr_exec & (i_rd_addr_exec != '0)
                      & ((i_rs1_used_dec & (i_rs1_addr_dec == i_rd_addr_exec))
                       | (i_rs2_used_dec & (i_rs2_addr_dec == i_rd_addr_exec)));

    assign w_mc_stall = (w_pending[i_rs1_addr_dec] & i_rs1_used_dec)
                      | (w_pending[i_rs2_addr_dec] & i_rs2_used_dec)
                      |  w_pending[i_rd_addr_dec]
                      | (i_mc_op_dec & w_sb_full);

    assign w_hazard_stall = w_load_use | w_mc_stall;

    assign o_stall_fetch = w_hazard_stall | i_stall_i | i_stall_d;
    assign o_stall_dec   = o_stall_fetch;
    assign o_stall_exec  = i_stall_d;
    assign o_stall_mem   = i_stall_d;
    assign o_flush_dec   = i_pc_src_exec & ~i_stall_d;
    assign o_flush_exec  = o_flush_dec | (w_hazard_stall & ~i_stall_d);

    assign w_issue = i_mc_issue_exec & ~i_stall_d & (i_rd_addr_exec != '0);

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .MC_DEPTH   (MC_DEPTH)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_arstn    (i_arstn),
        .i_issue    (w_issue),
        .i_issue_rd (i_rd_addr_exec),
        .i_done     (i_mc_done),
        .i_done_rd  (i_mc_rd),
        .i_clr      (i_cnt_clr),
        .o_pending  (w_pending),
        .o_full     (w_sb_full),
        .o_busy     (o_mc_busy),
        .o_err      (o_sb_err)
    );

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_stall_dec && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (o_flush_dec && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit_mc
// Description : Scoreboard bench for hazard_unit_mc against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_unit_mc;
    import hazard_pkg::*;

    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic          arstn;
        logic [AW-1:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec;
        logic [AW-1:0] rd_dec, rd_exec, rd_mem, rd_wb, mc_rd;
        logic          used1, used2, mc_op, mc_issue, mc_done;
        logic          we_mem, we_wb, pc_src, load, stall_i, stall_d, clr;
    } stim_t;

    typedef struct {
        bit       sf, sdec, sexe, smem, fdec, fexe;
        bit [1:0] f1, f2;
        bit       busy, err;
        int       scnt, fcnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arstn;
    logic [AW-1:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec;
    logic [AW-1:0] rd_dec, rd_exec, rd_mem, rd_wb, mc_rd;
    logic          used1, used2, mc_op, mc_issue, mc_done;
    logic          we_mem, we_wb, pc_src, load, stall_i, stall_d, clr;

    logic          stall_fetch, stall_dec, stall_exec, stall_mem;
    logic          flush_dec, flush_exec, mc_busy, sb_err;
    fwd_sel_t      fwd1, fwd2;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_unit_mc #(
        .REG_ADDR_W (AW),
        .MC_DEPTH   (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .i_clk             (clk),
        .i_arstn           (arstn),
        .i_rs1_addr_dec    (rs1_dec),
        .i_rs2_addr_dec    (rs2_dec),
        .i_rs1_addr_exec   (rs1_exec),
        .i_rs2_addr_exec   (rs2_exec),
        .i_rd_addr_dec     (rd_dec),
        .i_rd_addr_exec    (rd_exec),
        .i_rd_addr_mem     (rd_mem),
        .i_rd_addr_wb      (rd_wb),
        .i_rs1_used_dec    (used1),
        .i_rs2_used_dec    (used2),
        .i_mc_op_dec       (mc_op),
        .i_mc_issue_exec   (mc_issue),
        .i_mc_done         (mc_done),
        .i_mc_rd           (mc_rd),
        .i_reg_we_mem      (we_mem),
        .i_reg_we_wb       (we_wb),
        .i_pc_src_exec     (pc_src),
        .i_load_instr_exec (load),
        .i_stall_i         (stall_i),
        .i_stall_d         (stall_d),
        .i_cnt_clr         (clr),
        .o_stall_fetch     (stall_fetch),
        .o_stall_dec       (stall_dec),
        .o_stall_exec      (stall_exec),
        .o_stall_mem       (stall_mem),
        .o_flush_dec       (flush_dec),
        .o_flush_exec      (flush_exec),
        .o_forward_rs1     (fwd1),
        .o_forward_rs2     (fwd2),
        .o_mc_busy         (mc_busy),
        .o_sb_err          (sb_err),
        .o_stall_cnt       (stall_cnt),
        .o_flush_cnt       (flush_cnt)
    );

    // Reference model state: one flag per architectural register plus counts
    bit   m_pend [32];
    int   m_count, m_scnt, m_fcnt;
    bit   m_err;
    exp_t q[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.arstn = 1'b1;
        return s;
    endfunction

    function automatic bit pend(input logic [AW-1:0] a);
        return (a != 0) && m_pend[a];
    endfunction

    function automatic bit [1:0] fwd_of(input stim_t s, input logic [AW-1:0] rs);
        if (s.we_mem && s.rd_mem != 0 && s.rd_mem == rs) return 2'b10;
        if (s.we_wb && s.rd_wb != 0 && s.rd_wb == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
        m_scnt  = 0;
        m_fcnt  = 0;
    endtask

    task automatic model_clock(input stim_t s, input bit sdec, input bit fdec);
        bit iss, iok, dok, nerr;
        iss  = s.mc_issue && !s.stall_d && s.rd_exec != 0;
        iok  = iss && (m_count < DEPTH);
        dok  = s.mc_done && pend(s.mc_rd);
        nerr = (iss && !iok) || (s.mc_done && !dok);
        if (dok) m_pend[s.mc_rd] = 1'b0;
        if (iok) m_pend[s.rd_exec] = 1'b1;
        m_count = m_count + int'(iok) - int'(dok);
        if (s.clr) begin
            m_err  = 1'b0;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            m_err = m_err | nerr;
            if (sdec && m_scnt < CMAX) m_scnt++;
            if (fdec && m_fcnt < CMAX) m_fcnt++;
        end
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        bit   lu, mcs;
        @(negedge clk);
        arstn = s.arstn;   rs1_dec = s.rs1_dec;   rs2_dec = s.rs2_dec;
        rs1_exec = s.rs1_exec; rs2_exec = s.rs2_exec; rd_dec = s.rd_dec;
        rd_exec = s.rd_exec; rd_mem = s.rd_mem; rd_wb = s.rd_wb; mc_rd = s.mc_rd;
        used1 = s.used1;   used2 = s.used2;   mc_op = s.mc_op;
        mc_issue = s.mc_issue; mc_done = s.mc_done; we_mem = s.we_mem;
        we_wb = s.we_wb;   pc_src = s.pc_src; load = s.load;
        stall_i = s.stall_i; stall_d = s.stall_d; clr = s.clr;
        if (!s.arstn) model_reset();
        lu  = s.load && s.rd_exec != 0 &&
              ((s.used1 && s.rs1_dec == s.rd_exec) || (s.used2 && s.rs2_dec == s.rd_exec));
        mcs = (pend(s.rs1_dec) && s.used1) || (pend(s.rs2_dec) && s.used2) ||
              pend(s.rd_dec) || (s.mc_op && m_count == DEPTH);
        e.sdec = lu || mcs || s.stall_i || s.stall_d;
        e.sf   = e.sdec;
        e.sexe = s.stall_d;
        e.smem = s.stall_d;
        e.fdec = s.pc_src && !s.stall_d;
        e.fexe = e.fdec || ((lu || mcs) && !s.stall_d);
        e.f1   = fwd_of(s, s.rs1_exec);
        e.f2   = fwd_of(s, s.rs2_exec);
        e.busy = (m_count != 0);
        e.err  = m_err;
        e.scnt = m_scnt;
        e.fcnt = m_fcnt;
        q.push_back(e);
        n_vec++;
        @(posedge clk);
        if (s.arstn) model_clock(s, e.sdec, e.fdec);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec=%0d got=%0h exp=%0h", name, n_cmp, act, exp);
        end
    endtask

    // Monitor: samples between edges and compares against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_fetch", 32'(stall_fetch), 32'(e.sf));
                chk("stall_dec",   32'(stall_dec),   32'(e.sdec));
                chk("stall_exec",  32'(stall_exec),  32'(e.sexe));
                chk("stall_mem",   32'(stall_mem),   32'(e.smem));
                chk("flush_dec",   32'(flush_dec),   32'(e.fdec));
                chk("flush_exec",  32'(flush_exec),  32'(e.fexe));
                chk("forward_rs1", 32'(fwd1),        32'(e.f1));
                chk("forward_rs2", 32'(fwd2),        32'(e.f2));
                chk("mc_busy",     32'(mc_busy),     32'(e.busy));
                chk("sb_err",      32'(sb_err),      32'(e.err));
                chk("stall_cnt",   32'(stall_cnt),   32'(e.scnt));
                chk("flush_cnt",   32'(flush_cnt),   32'(e.fcnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t v;
        arstn = 1'b0; rs1_dec = '0; rs2_dec = '0; rs1_exec = '0; rs2_exec = '0;
        rd_dec = '0; rd_exec = '0; rd_mem = '0; rd_wb = '0; mc_rd = '0;
        used1 = 0; used2 = 0; mc_op = 0; mc_issue = 0; mc_done = 0;
        we_mem = 0; we_wb = 0; pc_src = 0; load = 0; stall_i = 0; stall_d = 0; clr = 0;
        model_reset();

        v = idle(); v.arstn = 1'b0; apply(v); apply(v);

        // Forwarding priority and x0
        v = idle(); v.rs1_exec = 5; v.rd_mem = 5; v.we_mem = 1; v.rd_wb = 5; v.we_wb = 1; apply(v);
        v = idle(); v.rs2_exec = 6; v.rd_wb = 6; v.we_wb = 1; apply(v);
        v = idle(); v.rs1_exec = 0; v.rd_mem = 0; v.we_mem = 1; apply(v);

        // Load-use
        v = idle(); v.load = 1; v.rd_exec = 7; v.rs2_dec = 7; v.used2 = 1; apply(v);
        v.used2 = 0; apply(v);

        // Multi-cycle op RAW stall and release
        v = idle(); v.mc_issue = 1; v.rd_exec = 9; apply(v);
        v = idle(); v.rs1_dec = 9; v.used1 = 1; apply(v);
        v.mc_done = 1; v.mc_rd = 9; apply(v);
        v.mc_done = 0; apply(v);

        // Depth limit, forced overflow, same-cycle issue/retire
        v = idle(); v.mc_issue = 1; v.rd_exec = 3; apply(v);
        v.rd_exec = 4; apply(v);
        v = idle(); v.mc_op = 1; apply(v);
        v = idle(); v.mc_issue = 1; v.rd_exec = 5; apply(v);
        v = idle(); v.mc_done = 1; v.mc_rd = 3; apply(v);
        v = idle(); v.mc_issue = 1; v.rd_exec = 4; v.mc_done = 1; v.mc_rd = 4; apply(v);
        v = idle(); v.rd_dec = 4; apply(v);
        v = idle(); v.mc_done = 1; v.mc_rd = 4; apply(v);
        v = idle(); v.mc_done = 1; v.mc_rd = 4; apply(v);
        v = idle(); v.clr = 1; apply(v);

        // Counter saturation then clear
        v = idle(); v.stall_i = 1;
        for (int i = 0; i < 20; i++) apply(v);
        v = idle(); v.pc_src = 1; v.clr = 1; apply(v);
        v = idle(); v.pc_src = 1; apply(v);
        v = idle(); apply(v);

        // Randomised traffic with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            v.arstn    = !(i == 150 || i == 151);
            v.rs1_dec  = AW'($urandom_range(0, 7));
            v.rs2_dec  = AW'($urandom_range(0, 7));
            v.rs1_exec = AW'($urandom_range(0, 7));
            v.rs2_exec = AW'($urandom_range(0, 7));
            v.rd_dec   = AW'($urandom_range(0, 7));
            v.rd_exec  = AW'($urandom_range(0, 7));
            v.rd_mem   = AW'($urandom_range(0, 7));
            v.rd_wb    = AW'($urandom_range(0, 7));
            v.mc_rd    = AW'($urandom_range(0, 7));
            v.used1    = 1'($urandom_range(0, 1));
            v.used2    = 1'($urandom_range(0, 1));
            v.mc_op    = ($urandom_range(0, 3) == 0);
            v.mc_issue = ($urandom_range(0, 3) == 0);
            v.mc_done  = ($urandom_range(0, 3) == 0);
            v.we_mem   = 1'($urandom_range(0, 1));
            v.we_wb    = 1'($urandom_range(0, 1));
            v.pc_src   = ($urandom_range(0, 3) == 0);
            v.load     = ($urandom_range(0, 2) == 0);
            v.stall_i  = ($urandom_range(0, 7) == 0);
            v.stall_d  = ($urandom_range(0, 7) == 0);
            v.clr      = ($urandom_range(0, 31) == 0);
            apply(v);
        end

        for (int i = 0; i < 3 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #4;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
